// File: rtl/seq_divider_if.sv
// Handshake and result bundle for seq_divider: the master issues operands, the
// slave (the divider) returns busy/done and the registered results.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per cycle, with start/busy/done.
// Signed operation is compiled in only when SEQ_DIVIDER_SIGNED_EN is defined.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic         CLK,
  input  logic         RST,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_OPER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] q_q, q_d, d_q, d_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q, sgn_d, zero_q, zero_d;
  logic             busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;

  logic             mode_s;
  logic [WIDTH:0]   t_s;
  logic [WIDTH+1:0] diff_s;
  logic [WIDTH-1:0] abs_dvd_s, abs_dvs_s, fix_quo_s, fix_rem_s;
  logic             unused_s;

`ifdef SEQ_DIVIDER_SIGNED_EN
  // Magnitudes feed the unsigned core; the signs are reapplied at FIX.
  assign mode_s    = bus.is_signed;
  assign abs_dvd_s = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
  assign abs_dvs_s = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
  assign fix_quo_s = (sgn_q && (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1])) ? -q_q : q_q;
  assign fix_rem_s = (sgn_q && dvd_q[WIDTH-1]) ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
  assign unused_s  = r_q[WIDTH];
`else
  assign mode_s    = 1'b0;
  assign abs_dvd_s = dvd_q;
  assign abs_dvs_s = dvs_q;
  assign fix_quo_s = q_q;
  assign fix_rem_s = r_q[WIDTH-1:0];
  assign unused_s  = r_q[WIDTH] ^ bus.is_signed ^ sgn_q;
`endif

  // One extra bit on the subtraction so its MSB is a clean borrow (T < D).
  assign t_s    = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign diff_s = {1'b0, t_s} - {2'b00, d_q};

  // Next-state and datapath update for the controller.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    sgn_d   = sgn_q;
    zero_d  = zero_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_INIT;
          dvd_d   = bus.dividend;
          dvs_d   = bus.divisor;
          sgn_d   = mode_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INIT: begin
        if (dvs_q == {WIDTH{1'b0}}) begin
          zero_d  = 1'b1;
          state_d = S_FIX;
        end else begin
          zero_d  = 1'b0;
          q_d     = abs_dvd_s;
          d_d     = abs_dvs_s;
          r_d     = {(WIDTH+1){1'b0}};
          cnt_d   = CW'(WIDTH);
          state_d = S_OPER;
        end
      end
      S_OPER: begin
        if (!diff_s[WIDTH+1]) begin
          r_d = diff_s[WIDTH:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = t_s;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_d == {CW{1'b0}}) begin
          state_d = S_FIX;
        end else begin
          state_d = S_OPER;
        end
      end
      S_FIX: begin
        if (zero_q) begin
          quo_d = {WIDTH{1'b1}};
          rem_d = dvd_q;
          dbz_d = 1'b1;
        end else begin
          quo_d = fix_quo_s;
          rem_d = fix_rem_s;
          dbz_d = 1'b0;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_INIT) || (state_d == S_OPER) || (state_d == S_FIX);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and output registers; reset clears everything.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      dvd_q   <= {WIDTH{1'b0}};
      dvs_q   <= {WIDTH{1'b0}};
      sgn_q   <= 1'b0;
      zero_q  <= 1'b0;
      q_q     <= {WIDTH{1'b0}};
      d_q     <= {WIDTH{1'b0}};
      r_q     <= {(WIDTH+1){1'b0}};
      cnt_q   <= {CW{1'b0}};
      quo_q   <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      sgn_q   <= sgn_d;
      zero_q  <= zero_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed plus randomized bench for seq_divider at WIDTH=8 against an
// arithmetic reference model (signed mode follows SEQ_DIVIDER_SIGNED_EN).
module tb_seq_divider;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; SV / and % truncate toward zero.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    int  sa, sb;
    bit  sm;
`ifdef SEQ_DIVIDER_SIGNED_EN
    sm = s;
`else
    sm = 1'b0;
`endif
    if (b == '0) begin
      q = '1; r = a; z = 1'b1;
    end else if (sm) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = W'(sa / sb);
      r  = W'(sa % sb);
      z  = 1'b0;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input bit glitch, input bit done_start);
    logic [W-1:0] eq, er;
    logic         ez;
    int           cyc, busy_cnt, exp_lat;
    model(a, b, s, eq, er, ez);
    exp_lat = (b == '0) ? 2 : W + 2;
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b; bus.is_signed = s;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dividend = W'($urandom); bus.divisor = W'($urandom); bus.is_signed = 1'($urandom);
    cyc = 0; busy_cnt = 0;
    while (bus.done !== 1'b1 && cyc < 64) begin
      if (bus.busy === 1'b1) busy_cnt++;
      bus.start = (glitch && cyc == 3);
      if (bus.start) begin
        bus.dividend = W'($urandom); bus.divisor = W'($urandom | 1);
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check("latency", cyc, exp_lat);
    check("busy_cycles", busy_cnt, exp_lat);
    check("quotient", bus.quotient, eq);
    check("remainder", bus.remainder, er);
    check("div_by_zero", bus.div_by_zero, ez);
    if (done_start) begin
      bus.start = 1'b1; bus.dividend = W'($urandom); bus.divisor = W'($urandom | 1);
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("done_one_pulse", bus.done, 1'b0);
    check("idle_not_busy", bus.busy, 1'b0);
    check("quotient_hold", bus.quotient, eq);
    if (done_start) begin
      @(negedge clk);
      check("start_in_done_ignored", bus.busy, 1'b0);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    vectors = 0; miscompares = 0;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = '0; bus.divisor = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_dbz", bus.div_by_zero, 1'b0);
    rst_n = 1'b1;

    run_op(8'd200, 8'd7, 1'b0, 1'b0, 1'b0);
    run_op(8'h9C, 8'd7, 1'b1, 1'b0, 1'b0);   // -100 / 7
    run_op(8'h80, 8'hFF, 1'b1, 1'b0, 1'b0);  // MIN / -1
    run_op(8'd55, 8'd0, 1'b0, 1'b0, 1'b0);
    run_op(8'd9, 8'd3, 1'b0, 1'b0, 1'b0);
    run_op(8'hF0, 8'h03, 1'b1, 1'b0, 1'b0);
    run_op(8'h85, 8'd0, 1'b1, 1'b0, 1'b0);
    run_op(8'd123, 8'd10, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of an operation.
    @(negedge clk);
    bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd7; bus.is_signed = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_quotient", bus.quotient, 0);
    check("abort_remainder", bus.remainder, 0);
    check("abort_dbz", bus.div_by_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd255, 8'd16, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 8 == 0) rb = '0;
      if (i % 10 == 1) ra = 8'h80;
      if (i % 10 == 2) rb = 8'hFF;
      if (i % 10 == 3) rb = 8'd1;
      run_op(ra, rb, 1'($urandom), 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
